// File: rtl/usb_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_arbiter_pkg
//  Description : Shared widths, logic levels, arbiter state encoding and the
//                round-robin pick helper for the USB TX arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_arbiter_pkg;

    localparam int USB_DATA_NBIT = 16;
    localparam int USB_ADDR_NBIT = 8;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    typedef enum logic [2:0] {
        ST_ARB_IDLE  = 3'd0,
        ST_ARB_FILL  = 3'd1,
        ST_ARB_PAD   = 3'd2,
        ST_ARB_SEND  = 3'd3,
        ST_ARB_DRAIN = 3'd4
    } arb_state_t;

    // First requesting index after 'last', modulo n (n = 1..4).
    // Scans downward so the closest candidate after 'last' overwrites the rest.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last,
                                           input int         n);
        logic [1:0] pick;
        int         cand;
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            if (i <= n) begin
                cand = (int'(last) + i) % n;
                if (req[cand[1:0]]) pick = cand[1:0];
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_arbiter_cache_ram.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_cache_ram
//  Description : Simple dual-port packet cache, synchronous write port and a
//                registered read port that clears on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_cache_ram
    import usb_tx_arbiter_pkg::*;
#(
    parameter int ADDR_NBIT = USB_ADDR_NBIT,
    parameter int DATA_NBIT = USB_DATA_NBIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_NBIT-1:0] waddr,
    input  logic [DATA_NBIT-1:0] wdata,
    input  logic [ADDR_NBIT-1:0] raddr,
    output logic [DATA_NBIT-1:0] rdata
);

    logic [DATA_NBIT-1:0] r_mem [0:(1 << ADDR_NBIT)-1];

    // Write port; storage itself is never reset
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_arbiter
//  Description : Round-robin sharing of the USB TX packet path. The granted
//                requester fills the TX cache, the tail is padded, a start
//                pulse goes to the slave-FIFO writer, which then drains it.
//                Optional header word at address 0: define USB_TX_HDR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_arbiter
    import usb_tx_arbiter_pkg::*;
#(
    parameter int                       NUM_REQ       = 2,
    parameter logic [USB_DATA_NBIT-1:0] PAD_WORD      = '0,
    parameter int                       DRAIN_TIMEOUT = 65535
) (
    input  logic                              ifclk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    output logic [NUM_REQ-1:0]                gnt,
    input  logic [NUM_REQ-1:0]                src_vd,
    input  logic [NUM_REQ*USB_DATA_NBIT-1:0]  src_data,
    input  logic [NUM_REQ-1:0]                src_eop,
    output logic                              tx_cache_sop,
    input  logic [USB_ADDR_NBIT-1:0]          tx_cache_addr,
    output logic [USB_DATA_NBIT-1:0]          tx_cache_data,
    output logic                              busy,
    output logic                              tx_timeout
);

    localparam int TO_NBIT = (DRAIN_TIMEOUT < 2) ? 1 : $clog2(DRAIN_TIMEOUT);
    localparam logic [TO_NBIT-1:0]       TO_LAST   = TO_NBIT'(DRAIN_TIMEOUT - 1);
    localparam logic [USB_ADDR_NBIT-1:0] ADDR_LAST = '1;
    localparam int DW4 = 4 * USB_DATA_NBIT;
`ifdef USB_TX_HDR_EN
    localparam logic [USB_ADDR_NBIT-1:0] PTR_START = USB_ADDR_NBIT'(1);
    localparam int CNT_NBIT = USB_DATA_NBIT - 2;
`else
    localparam logic [USB_ADDR_NBIT-1:0] PTR_START = '0;
`endif

    arb_state_t                r_state;
    logic [NUM_REQ-1:0]        r_gnt;
    logic [1:0]                r_last;
    logic [1:0]                r_idx;
    logic [USB_ADDR_NBIT-1:0]  r_wr_ptr;
    logic [TO_NBIT-1:0]        r_to_cnt;
    logic                      r_addr_seen;
    logic                      r_sop;
    logic                      r_busy;
    logic                      r_timeout;

    // Requester vectors widened to the maximum of four so indexing is uniform
    logic [3:0]                w_req4;
    logic [3:0]                w_vd4;
    logic [3:0]                w_eop4;
    logic [DW4-1:0]            w_data4;
    logic [1:0]                w_pick;
    logic                      w_vd;
    logic                      w_eop;
    logic [USB_DATA_NBIT-1:0]  w_src_word;
    logic                      w_last_word;
    logic                      w_we;
    logic [USB_ADDR_NBIT-1:0]  w_waddr;
    logic [USB_DATA_NBIT-1:0]  w_wdata;
    logic [USB_DATA_NBIT-1:0]  w_ram_q;

    assign w_req4      = 4'(req);
    assign w_vd4       = 4'(src_vd);
    assign w_eop4      = 4'(src_eop);
    assign w_data4     = DW4'(src_data);
    assign w_pick      = rr_pick(w_req4, r_last, NUM_REQ);
    assign w_vd        = w_vd4[r_idx];
    assign w_eop       = w_eop4[r_idx];
    assign w_src_word  = w_data4[r_idx*USB_DATA_NBIT +: USB_DATA_NBIT];
    assign w_last_word = (r_wr_ptr == ADDR_LAST);
    assign w_waddr     = r_wr_ptr;

`ifdef USB_TX_HDR_EN
    logic [USB_DATA_NBIT-1:0]  r_hdr;
    logic                      r_rd_hdr;
    logic [CNT_NBIT-1:0]       w_hdr_cnt;
    logic [USB_DATA_NBIT-1:0]  w_hdr;

    // Payload occupies 1..wr_ptr, so wr_ptr is the word count; full saturates
    assign w_hdr_cnt = w_last_word ? '1 : CNT_NBIT'(r_wr_ptr);
    assign w_hdr     = {r_idx, w_hdr_cnt};

    // Address 0 reads come from the header register instead of the RAM
    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) r_rd_hdr <= LOW;
        else        r_rd_hdr <= (tx_cache_addr == '0);
    end

    assign tx_cache_data = r_rd_hdr ? r_hdr : w_ram_q;
`else
    assign tx_cache_data = w_ram_q;
`endif

    // RAM write port: granted requester data in FILL, pad value in PAD
    always_comb begin
        w_we    = LOW;
        w_wdata = PAD_WORD;
        case (r_state)
            ST_ARB_FILL: begin
                w_we    = w_vd;
                w_wdata = w_src_word;
            end
            ST_ARB_PAD:  w_we = HIGH;
            default:     w_we = LOW;
        endcase
    end

    // Arbitration, fill, pad, start pulse and drain sequencing
    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ARB_IDLE;
            r_gnt       <= '0;
            r_last      <= 2'(NUM_REQ - 1);
            r_idx       <= '0;
            r_wr_ptr    <= '0;
            r_to_cnt    <= '0;
            r_addr_seen <= LOW;
            r_sop       <= LOW;
            r_busy      <= LOW;
            r_timeout   <= LOW;
`ifdef USB_TX_HDR_EN
            r_hdr       <= '0;
`endif
        end else begin
            r_sop     <= LOW;
            r_timeout <= LOW;
            case (r_state)
                ST_ARB_IDLE: begin
                    if (|req) begin
                        r_gnt    <= NUM_REQ'(4'b0001 << w_pick);
                        r_idx    <= w_pick;
                        r_last   <= w_pick;
                        r_wr_ptr <= PTR_START;
                        r_busy   <= HIGH;
                        r_state  <= ST_ARB_FILL;
                    end
                end
                ST_ARB_FILL: begin
                    if (w_vd) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (w_eop || w_last_word) begin
                            r_gnt <= '0;
`ifdef USB_TX_HDR_EN
                            r_hdr <= w_hdr;
`endif
                            if (w_last_word) begin
                                r_state <= ST_ARB_SEND;
                                r_sop   <= HIGH;
                            end else begin
                                r_state <= ST_ARB_PAD;
                            end
                        end
                    end
                end
                ST_ARB_PAD: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_last_word) begin
                        r_state <= ST_ARB_SEND;
                        r_sop   <= HIGH;
                    end
                end
                ST_ARB_SEND: begin
                    r_state     <= ST_ARB_DRAIN;
                    r_to_cnt    <= '0;
                    r_addr_seen <= LOW;
                end
                ST_ARB_DRAIN: begin
                    // Last address seen: allow one more cycle for its read
                    if (r_addr_seen) begin
                        r_state <= ST_ARB_IDLE;
                        r_busy  <= LOW;
                    end else if (tx_cache_addr == ADDR_LAST) begin
                        r_addr_seen <= HIGH;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_timeout <= HIGH;
                        r_state   <= ST_ARB_IDLE;
                        r_busy    <= LOW;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ARB_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= LOW;
                end
            endcase
        end
    end

    usb_tx_cache_ram #(
        .ADDR_NBIT (USB_ADDR_NBIT),
        .DATA_NBIT (USB_DATA_NBIT)
    ) u_cache_ram (
        .clk   (ifclk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (tx_cache_addr),
        .rdata (w_ram_q)
    );

    assign gnt          = r_gnt;
    assign tx_cache_sop = r_sop;
    assign busy         = r_busy;
    assign tx_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_tx_arbiter
//  Description : Directed self-checking bench for usb_tx_arbiter with a
//                packet-image model and a per-cycle compare process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_arbiter;
    import usb_tx_arbiter_pkg::*;

    localparam int DW    = USB_DATA_NBIT;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << USB_ADDR_NBIT;
    localparam logic [DW-1:0] PADW = 16'hFFFF;

    logic ifclk = 1'b0;
    logic rst_n = 1'b0;

    // main instance
    logic [NR-1:0]      req      = '0;
    logic [NR-1:0]      src_vd   = '0;
    logic [NR-1:0]      src_eop  = '0;
    logic [NR*DW-1:0]   src_data = '0;
    logic [7:0]         tx_addr  = '0;
    logic [NR-1:0]      gnt;
    logic               sop;
    logic [DW-1:0]      tx_data;
    logic               busy;
    logic               tmo;

    // short-timeout instance
    logic [NR-1:0]      req_b  = '0;
    logic [NR-1:0]      vd_b   = '0;
    logic [NR-1:0]      eop_b  = '0;
    logic [NR*DW-1:0]   data_b = '0;
    logic [7:0]         addr_b = '0;
    logic [NR-1:0]      gnt_b;
    logic               sop_b;
    logic [DW-1:0]      tx_data_b;
    logic               busy_b;
    logic               tmo_b;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] obs     [DEPTH];
    int   m_last;
    int   sop_cnt   = 0;
    int   sop_b_cnt = 0;
    bit   drain_on  = 1'b0;
    bit   p_v       = 1'b0;
    logic [7:0] p_a = '0;
    bit   prev_sop  = 1'b0;

    usb_tx_arbiter #(.NUM_REQ(NR), .PAD_WORD(PADW)) dut (
        .ifclk(ifclk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .src_vd(src_vd), .src_data(src_data), .src_eop(src_eop),
        .tx_cache_sop(sop), .tx_cache_addr(tx_addr), .tx_cache_data(tx_data),
        .busy(busy), .tx_timeout(tmo)
    );

    usb_tx_arbiter #(.NUM_REQ(NR), .PAD_WORD(PADW), .DRAIN_TIMEOUT(100)) dut_to (
        .ifclk(ifclk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b),
        .src_vd(vd_b), .src_data(data_b), .src_eop(eop_b),
        .tx_cache_sop(sop_b), .tx_cache_addr(addr_b), .tx_cache_data(tx_data_b),
        .busy(busy_b), .tx_timeout(tmo_b)
    );

    always #10 ifclk = ~ifclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge ifclk);
        #1;
    endtask

    // round-robin rule: first requester after the last winner, modulo NR
    function automatic int model_rr(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++)
            if (r[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    // expected packet image: requester words then pad, capped at DEPTH
    task automatic build_exp(input int base, input int n);
        for (int a = 0; a < DEPTH; a++)
            exp_mem[a] = (a < n) ? 16'(base + a) : PADW;
    endtask

    // read pipeline: address sampled at the edge, data due half a cycle later
    always @(posedge ifclk) begin
        p_v <= drain_on;
        p_a <= tx_addr;
    end

    // per-cycle compare process
    always @(negedge ifclk) begin
        if (!rst_n) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_sop", 32'(sop), 0);
            chk("rst_tmo", 32'(tmo), 0);
            chk("rst_data", 32'(tx_data), 0);
            prev_sop = 1'b0;
        end else begin
            chk("tmo_never", 32'(tmo), 0);
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            if (p_v) begin
                obs[p_a] = tx_data;
                chk("rd_data", 32'(tx_data), 32'(exp_mem[p_a]));
            end
            if (sop) begin
                chk("sop_width", 32'(prev_sop), 0);
                sop_cnt++;
            end
            if (sop_b) sop_b_cnt++;
            prev_sop = sop;
        end
    end

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (gnt == '0 && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic wait_sop(input int s0);
        int n;
        n = 0;
        while (sop_cnt == s0 && n < 600) begin
            step();
            n++;
        end
        chk("sop_seen", 32'(sop_cnt), 32'(s0 + 1));
    endtask

    task automatic send_words(input int k, input int n, input int base,
                              input bit with_eop, input bit noise);
        int last_i;
        last_i = (n < DEPTH) ? n - 1 : DEPTH - 1;
        for (int i = 0; i < n; i++) begin
            src_vd  = '0;
            src_eop = '0;
            src_vd[k] = 1'b1;
            src_data[k*DW +: DW] = 16'(base + i);
            src_eop[k] = with_eop && (i == n - 1);
            if (noise) begin
                src_vd[1-k]  = i[0];
                src_eop[1-k] = i[0];
                src_data[(1-k)*DW +: DW] = 16'hDEAD;
            end
            step();
            chk("gnt_fill", 32'(gnt), (i >= last_i) ? 32'd0 : 32'(1 << k));
        end
        src_vd   = '0;
        src_eop  = '0;
        src_data = '0;
    endtask

    task automatic drain();
        for (int a = 0; a < DEPTH; a++) begin
            tx_addr  = 8'(a);
            drain_on = 1'b1;
            step();
        end
        drain_on = 1'b0;
        tx_addr  = '0;
        chk("busy_final_read", 32'(busy), 1);
        step();
        chk("busy_fall", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int cyc;
        int w;
        int s0;
        int first;
        int seq [4];
        seq = '{0, 1, 0, 1};

        rst_n = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        m_last = NR - 1;
        step();

        // round-robin with both requests held
        req = 2'b11;
        for (int p = 0; p < 4; p++) begin
            wait_gnt(cyc);
            if (p == 0) chk("rr_first_latency", 32'(cyc), 1);
            w = model_rr(2'b11, m_last);
            m_last = w;
            chk("rr_model", 32'(gnt), 32'(1 << w));
            chk("rr_literal", 32'(gnt), 32'(1 << seq[p]));
            build_exp(16'h0100 * (w + 1) + p * 16, 4);
            s0 = sop_cnt;
            send_words(w, 4, 16'h0100 * (w + 1) + p * 16, 1'b1, 1'b0);
            wait_sop(s0);
            drain();
            chk("rr_sop_once", 32'(sop_cnt), 32'(s0 + 1));
        end
        req = '0;
        step();

        // single packet from requester 0, 10 words with EOP
        req = 2'b01;
        step();
        w = model_rr(2'b01, m_last);
        m_last = w;
        chk("single_gnt", 32'(gnt), 32'(1 << w));
        chk("single_gnt_lit", 32'(gnt), 32'h1);
        req = '0;
        build_exp(0, 10);
        s0 = sop_cnt;
        send_words(0, 10, 0, 1'b1, 1'b0);
        wait_sop(s0);
        drain();
        chk("single_sop_once", 32'(sop_cnt), 32'(s0 + 1));
        chk("single_ram9", 32'(obs[9]), 32'h0009);
        chk("single_ram10", 32'(obs[10]), 32'hFFFF);
        chk("single_ram255", 32'(obs[255]), 32'hFFFF);

        // interference from requester 1 while 0 is granted
        req = 2'b01;
        step();
        w = model_rr(2'b01, m_last);
        m_last = w;
        chk("intf_gnt", 32'(gnt), 32'(1 << w));
        req = '0;
        build_exp(16'h0A00, 12);
        s0 = sop_cnt;
        send_words(0, 12, 16'h0A00, 1'b1, 1'b1);
        wait_sop(s0);
        drain();
        chk("intf_ram1", 32'(obs[1]), 32'h0A01);
        chk("intf_ram12", 32'(obs[12]), 32'hFFFF);

        // truncation: 300 words, no EOP
        req = 2'b01;
        step();
        w = model_rr(2'b01, m_last);
        m_last = w;
        chk("trunc_gnt", 32'(gnt), 32'(1 << w));
        req = '0;
        build_exp(16'h1000, 300);
        s0 = sop_cnt;
        send_words(0, 300, 16'h1000, 1'b0, 1'b0);
        wait_sop(s0);
        drain();
        chk("trunc_ram0", 32'(obs[0]), 32'h1000);
        chk("trunc_ram255", 32'(obs[255]), 32'h10FF);

        // reset in the middle of FILL
        req = 2'b01;
        step();
        chk("rstmid_gnt", 32'(gnt), 32'h1);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            src_vd = 2'b01;
            src_data[DW-1:0] = 16'(16'h3000 + i);
            step();
        end
        src_data[DW-1:0] = 16'h3005;
        rst_n = 1'b0;
        #1;
        chk("rstmid_gnt0", 32'(gnt), 0);
        chk("rstmid_busy0", 32'(busy), 0);
        chk("rstmid_sop0", 32'(sop), 0);
        src_vd   = '0;
        src_data = '0;
        m_last   = NR - 1;
        step();
        step();
        rst_n = 1'b1;
        req   = 2'b10;
        step();
        w = model_rr(2'b10, m_last);
        m_last = w;
        chk("rstmid_regrant", 32'(gnt), 32'(1 << w));
        chk("rstmid_regrant_lit", 32'(gnt), 32'h2);
        req = '0;
        build_exp(16'h2000, 3);
        s0 = sop_cnt;
        send_words(1, 3, 16'h2000, 1'b1, 1'b0);
        wait_sop(s0);
        drain();

        // drain timeout on the short-timeout instance
        req_b = 2'b01;
        step();
        chk("to_gnt", 32'(gnt_b), 32'h1);
        req_b = '0;
        vd_b  = 2'b01;
        eop_b = 2'b01;
        data_b[DW-1:0] = 16'h0001;
        step();
        vd_b   = '0;
        eop_b  = '0;
        data_b = '0;
        cyc = 0;
        while (sop_b_cnt == 0 && cyc < 600) begin
            step();
            cyc++;
        end
        chk("to_sop_seen", 32'(sop_b_cnt), 1);
        req_b = 2'b10;
        first = -1;
        for (int k = 1; k <= 102; k++) begin
            step();
            if (tmo_b && first < 0) first = k - 1;
            if (k == 100) begin
                chk("to_before_tmo", 32'(tmo_b), 0);
                chk("to_busy_held", 32'(busy_b), 1);
                chk("to_rd_word0", 32'(tx_data_b), 32'h0001);
            end
            if (k == 101) begin
                chk("to_tmo_pulse", 32'(tmo_b), 1);
                chk("to_busy_fall", 32'(busy_b), 0);
            end
            if (k == 102) begin
                chk("to_tmo_one_cycle", 32'(tmo_b), 0);
                chk("to_next_gnt", 32'(gnt_b), 32'h2);
            end
        end
        chk("to_delay", 32'(first), 100);
        req_b = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
Shares the USB TX packet path between NUM_REQ internal requesters (MIPI readback, status reporter, ...), using round-robin arbitration. It owns the TX cache RAM and lets the granted requester fill one packet. It pads the packet to full length and pulses tx_cache_sop to usb_slavefifo. It then serves tx_cache_data to the slave-FIFO writer until the packet is drained.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
PAD_WORD, 0, fill value for unused words after requester EOP
DRAIN_TIMEOUT, 65535, max ifclk cycles in DRAIN before forced abort

Ports:
ifclk  input  1  48 MHz interface clock
rst_n  input  1  reset; one clock, asynchronous assert, active-low
req  input  NUM_REQ  per-requester packet request, level, held until gnt
gnt  output  NUM_REQ  one-hot grant, registered
src_vd  input  NUM_REQ  per-requester data valid
src_data  input  NUM_REQ*USB_DATA_NBIT  concatenated data, requester i at slice i
src_eop  input  NUM_REQ  last word of packet, qualified by src_vd
tx_cache_sop  output  1  one-cycle start pulse to usb_slavefifo
tx_cache_addr  input  USB_ADDR_NBIT  read address from usb_slavefifo
tx_cache_data  output  USB_DATA_NBIT  RAM read data, 1-cycle registered latency
busy  output  1  high in any state other than IDLE
tx_timeout  output  1  one-cycle pulse on DRAIN abort

Behaviour:
- Reset values: gnt=0, tx_cache_sop=0, busy=0, tx_timeout=0, tx_cache_data=0. Write pointer is 0. Round-robin last-grant pointer is NUM_REQ-1, so requester 0 wins first. Reset mid-operation aborts the packet; RAM contents are don't-care.
- States: IDLE, FILL, PAD, SEND, DRAIN.
- IDLE: if any req is high, grant the first requesting index after the last-grant pointer (modulo NUM_REQ). gnt goes high on the next edge, with state FILL and wr_ptr=0. The last-grant pointer updates at grant time.
- FILL: only the granted requester's src_vd/src_data are written, to RAM[wr_ptr], and wr_ptr increments. Non-granted src_vd is ignored.
  - src_vd and src_eop together: write the word and drop gnt next edge. If wr_ptr was all-ones go to SEND, else go to PAD with wr_ptr+1.
  - src_vd with wr_ptr all-ones and no EOP: write the word, drop gnt, go to SEND. The packet is truncated; later words are ignored.
  - src_eop without src_vd is ignored.
- PAD: write PAD_WORD at wr_ptr each cycle until the all-ones address is written, then go to SEND.
- SEND: tx_cache_sop=1 for exactly one cycle, then go to DRAIN with the timeout counter cleared.
- DRAIN: wait until tx_cache_addr==all-ones is sampled, then one further cycle for the final read, then go to IDLE.
  - If the counter reaches DRAIN_TIMEOUT first: pulse tx_timeout and go to IDLE.
  - The earliest new grant is the IDLE cycle after the return.
- RAM read: tx_cache_data <= RAM[tx_cache_addr] every cycle regardless of state. Reads and writes never overlap because writes occur only in FILL/PAD.
- Packet length is always 2^USB_ADDR_NBIT words. Counters wrap modulo their width.
- Simultaneous requests: exactly one grant, in round-robin order. A requester dropping req while granted does not abort the packet; the packet completes via EOP, full, or pad.

Optional Feature:
USB_TX_HDR_EN:
- Defined: RAM[0] is a header {source index in 2 MSBs, payload word count in LSBs}. Requester data starts at address 1. The header is written on leaving FILL, in the same cycle as entry to PAD or SEND. A payload count equal to full capacity saturates at all-ones of the field.
- Undefined: no header; requester data starts at address 0.

Decomposition:
- globals.v: USB_DATA_NBIT, USB_ADDR_NBIT, LOW/HIGH, and the new state encodings ST_ARB_IDLE..ST_ARB_DRAIN (3 bits).
- Sub-module usb_tx_cache_ram: simple dual-port, 2^USB_ADDR_NBIT x USB_DATA_NBIT, with a synchronous write port and a registered read port.

Test Plan:
Bench settings: USB_ADDR_NBIT=8, USB_DATA_NBIT=16, NUM_REQ=2, PAD_WORD=16'hFFFF.
- Single packet: req[0], 10 words 0x0000..0x0009 with EOP on the last word. Expect:
  - gnt[0] one cycle after req;
  - RAM 0..9 = data, 10..255 = 0xFFFF;
  - one tx_cache_sop pulse;
  - after the bench drives addr 0..255, busy falls and state is IDLE.
- Round-robin: req[0] and req[1] held continuously. Grants alternate 0,1,0,1 across 4 packets, with no back-to-back gnt on the same index.
- Truncation: requester sends 300 words with no EOP. gnt drops after word 256, RAM[255]=word 255, words 256..299 are ignored, and SEND follows.
- Interference: src_vd[1] toggling with data 0xDEAD while gnt[0] is held. RAM contains only requester 0 data.
- Timeout: DRAIN_TIMEOUT=100, bench never drives addr 255. tx_timeout pulses exactly 100 cycles after DRAIN entry, and the next req is granted.
- Reset: rst_n low mid-FILL at word 5. gnt, busy, and tx_cache_sop are 0 immediately. After release, req[1] alone is granted within 1 cycle.
